// File: rtl/elixirchip_es1_spu_op_mem_rseq_if.sv
// Command and read-issue bundle of the mem-op read sequencer.
// s_repeat/s_stop exist only when ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN is defined.
interface elixirchip_es1_spu_op_mem_rseq_if #(
    parameter int ADDR_BITS  = 9,
    parameter int COUNT_BITS = 16
);
    // No back-pressure anywhere: s_start and m_rvalid are single-cycle strobes
    // that count only on cycles where the sequencer's cke is high.
    logic                  s_start;
    logic [ADDR_BITS-1:0]  s_base;
    logic [ADDR_BITS-1:0]  s_stride;
    logic [COUNT_BITS-1:0] s_count;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN
    logic                  s_repeat;
    logic                  s_stop;
`endif
    logic                  s_busy;
    logic [ADDR_BITS-1:0]  m_raddr;
    logic                  m_rvalid;
    logic                  m_rlast;
    logic                  m_dvalid;
    logic                  m_dlast;
    logic                  m_done;
    logic                  dbg_state;

    modport master (
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN
        output s_repeat, s_stop,
`endif
        output s_start, s_base, s_stride, s_count,
        input  s_busy, m_raddr, m_rvalid, m_rlast, m_dvalid, m_dlast, m_done, dbg_state
    );

    modport slave (
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN
        input  s_repeat, s_stop,
`endif
        input  s_start, s_base, s_stride, s_count,
        output s_busy, m_raddr, m_rvalid, m_rlast, m_dvalid, m_dlast, m_done, dbg_state
    );
endinterface

// File: rtl/elixirchip_es1_spu_op_mem_rseq.sv
// Read-address sequencer feeding elixirchip_es1_spu_op_mem, with a cke-qualified valid/last delay line.
// Optional repeat mode: ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN.
module elixirchip_es1_spu_op_mem_rseq #(
    parameter int    RLATENCY   = 1,
    parameter int    ADDR_BITS  = 9,
    parameter int    COUNT_BITS = 16,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    elixirchip_es1_spu_op_mem_rseq_if.slave bus
);
    // State is mirrored on dbg_state in debug builds and in RTL-level simulation.
    localparam bit DBG_EN = (DEBUG == "true") || (SIMULATION == "true" && DEVICE == "RTL");

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_BITS-1:0]  base_q;
    logic [ADDR_BITS-1:0]  stride_q;
    logic [COUNT_BITS-1:0] count_q;
    logic                  rep_q;
    logic [ADDR_BITS-1:0]  next_addr;
    logic [COUNT_BITS-1:0] remain;
    logic [ADDR_BITS-1:0]  raddr;
    logic                  rvalid;
    logic                  rlast;
    logic                  done;
    logic [RLATENCY-1:0]   dv_line;
    logic [RLATENCY-1:0]   dl_line;

    logic repeat_in;
    logic stop_in;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_RSEQ_REPEAT_EN
    assign repeat_in = bus.s_repeat;
    assign stop_in   = bus.s_stop;
`else
    assign repeat_in = 1'b0;
    assign stop_in   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            rep_q     <= 1'b0;
            next_addr <= '0;
            remain    <= '0;
            raddr     <= '0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            done      <= 1'b0;
            dv_line   <= '0;
            dl_line   <= '0;
        end else if (cke) begin
            dv_line <= RLATENCY'({dv_line, rvalid});
            dl_line <= RLATENCY'({dl_line, rlast});
            case (state)
                ST_IDLE: begin
                    raddr  <= '0;
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                    done   <= 1'b0;
                    if (bus.s_start) begin
                        base_q   <= bus.s_base;
                        stride_q <= bus.s_stride;
                        count_q  <= bus.s_count;
                        rep_q    <= repeat_in & ~stop_in;
                        if (bus.s_count != '0) begin
                            state     <= ST_RUN;
                            raddr     <= bus.s_base;
                            rvalid    <= 1'b1;
                            rlast     <= (bus.s_count == COUNT_BITS'(1));
                            done      <= (bus.s_count == COUNT_BITS'(1));
                            next_addr <= bus.s_base + bus.s_stride;
                            remain    <= bus.s_count - COUNT_BITS'(1);
                        end else begin
                            // Empty transfer: report completion without issuing anything.
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop_in) begin
                        rep_q <= 1'b0;
                    end
                    if (rlast) begin
                        if (rep_q && !stop_in) begin
                            // Next pass starts back-to-back from the latched command.
                            raddr     <= base_q;
                            rvalid    <= 1'b1;
                            rlast     <= (count_q == COUNT_BITS'(1));
                            done      <= (count_q == COUNT_BITS'(1));
                            next_addr <= base_q + stride_q;
                            remain    <= count_q - COUNT_BITS'(1);
                        end else begin
                            state  <= ST_IDLE;
                            raddr  <= '0;
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            done   <= 1'b0;
                        end
                    end else begin
                        raddr     <= next_addr;
                        rvalid    <= 1'b1;
                        rlast     <= (remain == COUNT_BITS'(1));
                        done      <= (remain == COUNT_BITS'(1));
                        next_addr <= next_addr + stride_q;
                        remain    <= remain - COUNT_BITS'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_busy    = (state == ST_RUN);
    assign bus.m_raddr   = raddr;
    assign bus.m_rvalid  = rvalid;
    assign bus.m_rlast   = rlast;
    assign bus.m_done    = done;
    assign bus.m_dvalid  = dv_line[RLATENCY-1];
    assign bus.m_dlast   = dl_line[RLATENCY-1];
    assign bus.dbg_state = DBG_EN ? (state == ST_RUN) : 1'b0;
endmodule
